// File: rtl/mar_burst_decoder.sv
// Memory address register with one-hot word-select decode, single-step
// increment with overflow flagging, and a self-timed burst walker.
//
// Handshake note: there is no valid/ready pair on this block. Command inputs
// (lm, burst_start, inc) are sampled on every rising edge while IDLE, and
// are ignored entirely while busy is high. busy is the only back-pressure
// indication the sequencer gets.
module mar_burst_decoder #(
  parameter int AW   = 4,
  parameter bit WRAP = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     win,
  input  logic              lm,
  input  logic              inc,
  input  logic              oe,
  input  logic              burst_start,
  input  logic [AW-1:0]     burst_len,
  output logic [AW-1:0]     addr,
  output logic [2**AW-1:0]  sel,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic              dbg_state
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [AW-1:0] TOP = '1;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic          at_top;
  logic [AW-1:0] addr_inc;

  // Successor address: wraps to zero or sticks at the top address.
  always_comb begin
    at_top   = (addr_q == TOP);
    addr_inc = addr_q + 1'b1;
    if (at_top) begin
      addr_inc = WRAP ? '0 : TOP;
    end
  end

  // State register; reset is asynchronous so a mid-burst reset acts at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic: IDLE honours lm > burst_start > inc; BURST counts down.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    ovf_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (lm) begin
          addr_d = win;
        end else if (burst_start) begin
          addr_d  = win;
          cnt_d   = burst_len;
          state_d = BURST;
        end else if (inc) begin
          addr_d = addr_inc;
          ovf_d  = at_top;
        end
      end
      BURST: begin
        if (cnt_q != '0) begin
          addr_d = addr_inc;
          cnt_d  = cnt_q - 1'b1;
          ovf_d  = at_top;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // One-hot word select, gated by the output enable.
  always_comb begin
    sel = '0;
    if (oe) begin
      sel[addr_q] = 1'b1;
    end
  end

  assign addr      = addr_q;
  assign busy      = (state_q == BURST);
  assign done      = (state_q == BURST) && (cnt_q == '0);
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mar_burst_decoder.sv
// Bench for mar_burst_decoder: one wrapping and one saturating instance
// share all inputs and are compared against a queue-based reference.
module tb_mar_burst_decoder;

  logic       clk;
  logic       rst;
  logic [3:0] win;
  logic       lm;
  logic       inc;
  logic       oe;
  logic       burst_start;
  logic [3:0] burst_len;

  logic [3:0]  addr_w, addr_s;
  logic [15:0] sel_w, sel_s;
  logic        busy_w, busy_s, done_w, done_s, ovf_w, ovf_s, dbg_w, dbg_s;

  int tests = 0;
  int fails = 0;

  // Reference model: current address per instance, pending ovf, and the
  // addresses still to be shown by an active burst (front = this cycle).
  logic [3:0] m_addr_w, m_addr_s;
  logic       m_ovf_w, m_ovf_s;
  logic [3:0] exp_q_w[$];
  logic [3:0] exp_q_s[$];

  mar_burst_decoder #(.AW(4), .WRAP(1'b1)) u_wrap (
    .clk(clk), .rst(rst), .win(win), .lm(lm), .inc(inc), .oe(oe),
    .burst_start(burst_start), .burst_len(burst_len),
    .addr(addr_w), .sel(sel_w), .busy(busy_w), .done(done_w), .ovf(ovf_w),
    .dbg_state(dbg_w)
  );

  mar_burst_decoder #(.AW(4), .WRAP(1'b0)) u_sat (
    .clk(clk), .rst(rst), .win(win), .lm(lm), .inc(inc), .oe(oe),
    .burst_start(burst_start), .burst_len(burst_len),
    .addr(addr_s), .sel(sel_s), .busy(busy_s), .done(done_s), .ovf(ovf_s),
    .dbg_state(dbg_s)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_addr_w = 4'h0;
    m_addr_s = 4'h0;
    m_ovf_w  = 1'b0;
    m_ovf_s  = 1'b0;
    exp_q_w.delete();
    exp_q_s.delete();
  endtask

  // Reference update for one rising edge, using the inputs held across it.
  task automatic model_edge();
    logic [3:0] prev_w, prev_s;
    int sum;
    if (rst) begin
      model_reset();
    end else if (exp_q_w.size() != 0) begin
      prev_w = exp_q_w.pop_front();
      prev_s = exp_q_s.pop_front();
      if (exp_q_w.size() != 0) begin
        m_ovf_w  = (prev_w == 4'hF);
        m_ovf_s  = (prev_s == 4'hF);
        m_addr_w = exp_q_w[0];
        m_addr_s = exp_q_s[0];
      end else begin
        m_ovf_w = 1'b0;
        m_ovf_s = 1'b0;
      end
    end else if (lm) begin
      m_addr_w = win;
      m_addr_s = win;
      m_ovf_w  = 1'b0;
      m_ovf_s  = 1'b0;
    end else if (burst_start) begin
      for (int i = 0; i <= int'(burst_len); i++) begin
        sum = int'(win) + i;
        exp_q_w.push_back(4'(sum % 16));
        exp_q_s.push_back((sum > 15) ? 4'hF : 4'(sum));
      end
      m_addr_w = win;
      m_addr_s = win;
      m_ovf_w  = 1'b0;
      m_ovf_s  = 1'b0;
    end else if (inc) begin
      m_ovf_w  = (m_addr_w == 4'hF);
      m_ovf_s  = (m_addr_s == 4'hF);
      m_addr_w = m_addr_w + 4'h1;
      m_addr_s = (m_addr_s == 4'hF) ? 4'hF : m_addr_s + 4'h1;
    end else begin
      m_ovf_w = 1'b0;
      m_ovf_s = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    logic in_burst, last;
    in_burst = (exp_q_w.size() != 0);
    last     = (exp_q_w.size() == 1);
    cmp({tag, " wrap addr"}, 16'(addr_w), 16'(m_addr_w));
    cmp({tag, " sat addr"},  16'(addr_s), 16'(m_addr_s));
    cmp({tag, " wrap sel"},  sel_w, oe ? (16'h1 << m_addr_w) : 16'h0);
    cmp({tag, " sat sel"},   sel_s, oe ? (16'h1 << m_addr_s) : 16'h0);
    cmp({tag, " wrap busy"}, 16'(busy_w), 16'(in_burst));
    cmp({tag, " sat busy"},  16'(busy_s), 16'(in_burst));
    cmp({tag, " wrap done"}, 16'(done_w), 16'(last));
    cmp({tag, " sat done"},  16'(done_s), 16'(last));
    cmp({tag, " wrap ovf"},  16'(ovf_w), 16'(m_ovf_w));
    cmp({tag, " sat ovf"},   16'(ovf_s), 16'(m_ovf_s));
  endtask

  // Driver: one clock with the currently driven inputs, then check.
  task automatic step(input string tag);
    @(posedge clk);
    #1;
    model_edge();
    check_all(tag);
  endtask

  task automatic idle_in();
    lm = 1'b0; inc = 1'b0; burst_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; win = 4'h0; lm = 1'b0; inc = 1'b0; oe = 1'b1;
    burst_start = 1'b0; burst_len = 4'h0;
    model_reset();

    // Reset and decode
    step("reset");
    rst = 1'b0;
    step("post_reset");
    lm = 1'b1; win = 4'hA;
    step("load_a");
    cmp("load_a sel const", sel_w, 16'h0400);
    idle_in(); oe = 1'b0;
    #1 check_all("oe_off");
    oe = 1'b1;

    // Wrap / saturate at the top address
    lm = 1'b1; win = 4'hF;
    step("load_f");
    lm = 1'b0; inc = 1'b1;
    step("inc_top");
    step("inc_again");
    inc = 1'b0;
    step("ovf_clear");

    // Plain burst 3,4,5
    burst_start = 1'b1; win = 4'h3; burst_len = 4'h2;
    step("burst3 c0");
    cmp("burst3 c0 addr const", 16'(addr_w), 16'h3);
    idle_in();
    step("burst3 c1");
    step("burst3 c2");
    cmp("burst3 done const", 16'(done_w), 16'h1);
    step("burst3 idle");

    // lm wins over burst_start
    lm = 1'b1; burst_start = 1'b1; win = 4'h7; burst_len = 4'h5;
    step("lm_over_bs");
    idle_in();
    step("lm_over_bs hold");

    // Commands during a burst are ignored
    burst_start = 1'b1; win = 4'h9; burst_len = 4'h3;
    step("ign c0");
    burst_start = 1'b0; lm = 1'b1; win = 4'h0;
    step("ign c1");
    lm = 1'b0; inc = 1'b1;
    step("ign c2");
    inc = 1'b0; burst_start = 1'b1;
    step("ign c3");
    idle_in();
    step("ign idle");

    // Boundary burst across the top address
    burst_start = 1'b1; win = 4'hE; burst_len = 4'h2;
    step("edge c0");
    idle_in();
    step("edge c1");
    step("edge c2");
    step("edge idle");

    // burst_len = 0: single done cycle
    burst_start = 1'b1; win = 4'h6; burst_len = 4'h0;
    step("len0 c0");
    idle_in();
    step("len0 idle");

    // Asynchronous reset in the middle of a burst
    burst_start = 1'b1; win = 4'h2; burst_len = 4'h5;
    step("mid c0");
    idle_in();
    step("mid c1");
    #2 rst = 1'b1;
    #1 model_reset();
    check_all("async_rst");
    #1 rst = 1'b0;
    step("after_rst");
    lm = 1'b1; win = 4'hC;
    step("lm_after_rst");
    idle_in();

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      lm          = ($urandom_range(0, 7) == 0);
      burst_start = ($urandom_range(0, 5) == 0);
      inc         = ($urandom_range(0, 2) == 0);
      oe          = ($urandom_range(0, 3) != 0);
      win         = 4'($urandom_range(0, 15));
      burst_len   = 4'($urandom_range(0, 15));
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
